// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and shared cache port signals for mem_port_arbiter.
// slave is the arbiter's view; master is the requester/cache view.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_read;
  logic [WIDTH-1:0] i_address;
  logic [WIDTH-1:0] i_rdata;
  logic             i_resp;

  logic             d_read;
  logic             d_write;
  logic [WIDTH-1:0] d_address;
  logic [WIDTH-1:0] d_wdata;
  logic [3:0]       d_byte_enable;
  logic [WIDTH-1:0] d_rdata;
  logic             d_resp;

  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_byte_enable;
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  mem_resp, mem_rdata,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
    output mem_resp, mem_rdata,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter onto one cache port; command 1 cycle after request, held until mem_resp, 1 idle turnaround.
// ARB_ROUND_ROBIN_EN: alternate on contention; undefined: data side always wins.
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t           state_q, state_d;
  logic             rd_q, rd_d, wr_q, wr_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             d_req, grant_d, resp_ok;

`ifdef ARB_ROUND_ROBIN_EN
  logic             last_d_q, last_d_d;
`endif

  assign d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = d_req & (~bus.i_read | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          // a simultaneous read+write is issued as a write
          state_d = SERVE_D;
          wr_d    = bus.d_write;
          rd_d    = ~bus.d_write;
          addr_d  = bus.d_address;
          wdata_d = bus.d_wdata;
          be_d    = bus.d_write ? bus.d_byte_enable : 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (bus.i_read) begin
          state_d = SERVE_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = bus.i_address;
          wdata_d = '0;
          be_d    = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'h0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // a response coinciding with reset belongs to a command being dropped
  assign resp_ok = bus.mem_resp & ~rst;

  assign bus.i_resp  = (state_q == SERVE_I) & resp_ok;
  assign bus.d_resp  = (state_q == SERVE_D) & resp_ok;
  assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : '0;

  assign bus.mem_read        = rd_q;
  assign bus.mem_write       = wr_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed stimulus with a scoreboard: expected commands and responses are queued, a negedge monitor checks them.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.WIDTH(32)) bus ();

  mem_port_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        side_d;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  len;  // expected command length in cycles, 0 = unchecked
  } cmd_t;

  resp_t resp_q[$];
  cmd_t  cmd_q[$];
  cmd_t  cur;
  logic  cmd_active = 1'b0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // request already driven; enter SERVE, respond on the n-th SERVE cycle, return to IDLE
  task automatic serve(input int n, input logic [31:0] rdata);
    tick();
    repeat (n - 1) tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  function automatic cmd_t mk_cmd(logic rd, logic wr, logic [31:0] a, logic [31:0] w,
                                  logic [3:0] be, logic [7:0] len);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = w; c.be = be; c.len = len;
    return c;
  endfunction

  function automatic resp_t mk_resp(logic side_d, logic [31:0] r);
    resp_t e;
    e.side_d = side_d; e.rdata = r;
    return e;
  endfunction

  // monitor
  always @(negedge clk) begin
    resp_t e;
    if (bus.i_resp === 1'b1 || bus.d_resp === 1'b1) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", {bus.i_resp, bus.d_resp}, 2'b00);
      end else begin
        e = resp_q.pop_front();
        chk("resp_side", {bus.i_resp, bus.d_resp}, {~e.side_d, e.side_d});
        chk("resp_rdata", e.side_d ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end
    if (bus.mem_resp === 1'b1) begin
      if (bus.i_resp !== 1'b1) chk("i_rdata_zero", bus.i_rdata, 32'h0);
      if (bus.d_resp !== 1'b1) chk("d_rdata_zero", bus.d_rdata, 32'h0);
    end
    if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
      if (!cmd_active) begin
        cmd_active = 1'b1;
        cyc = 1;
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", 1'b1, 1'b0);
          cur = mk_cmd(bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata,
                       bus.mem_byte_enable, 8'd0);
        end else begin
          cur = cmd_q.pop_front();
          chk("cmd_rdwr", {bus.mem_read, bus.mem_write}, {cur.rd, cur.wr});
          chk("cmd_addr", bus.mem_address, cur.addr);
          chk("cmd_wdata", bus.mem_wdata, cur.wdata);
          chk("cmd_be", bus.mem_byte_enable, cur.be);
        end
      end else begin
        cyc++;
        chk("cmd_stable_addr", bus.mem_address, cur.addr);
        chk("cmd_stable_ctl", {bus.mem_read, bus.mem_write, bus.mem_byte_enable, bus.mem_wdata},
            {cur.rd, cur.wr, cur.be, cur.wdata});
      end
    end else if (cmd_active) begin
      if (cur.len != 0) chk("cmd_len", cyc, cur.len);
      cmd_active = 1'b0;
    end
  end

  initial begin
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.d_byte_enable = '0; bus.mem_resp = 0; bus.mem_rdata = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_mem_addr", bus.mem_address, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", bus.mem_byte_enable, 4'h0);
    chk("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    tick();
    rst = 1'b0;

    // single fetch, response on 3rd SERVE_I cycle
    bus.i_read = 1; bus.i_address = 32'h100;
    cmd_q.push_back(mk_cmd(1, 0, 32'h100, 32'h0, 4'hF, 8'd3));
    resp_q.push_back(mk_resp(0, 32'hDEADBEEF));
    serve(3, 32'hDEADBEEF);
    bus.i_read = 0;
    tick();

    // store with partial mask
    bus.d_write = 1; bus.d_address = 32'h204; bus.d_wdata = 32'h55; bus.d_byte_enable = 4'b0010;
    cmd_q.push_back(mk_cmd(0, 1, 32'h204, 32'h55, 4'b0010, 8'd2));
    resp_q.push_back(mk_resp(1, 32'h0BADF00D));
    serve(2, 32'h0BADF00D);
    bus.d_write = 0;
    tick();

    // read and write together issue a write
    bus.d_read = 1; bus.d_write = 1; bus.d_address = 32'h300; bus.d_wdata = 32'h1234;
    bus.d_byte_enable = 4'b0101;
    cmd_q.push_back(mk_cmd(0, 1, 32'h300, 32'h1234, 4'b0101, 8'd1));
    resp_q.push_back(mk_resp(1, 32'hCAFE));
    serve(1, 32'hCAFE);
    bus.d_read = 0; bus.d_write = 0;
    tick();

    // load forces full byte mask
    bus.d_read = 1; bus.d_address = 32'h40; bus.d_wdata = 32'h0; bus.d_byte_enable = 4'b0011;
    cmd_q.push_back(mk_cmd(1, 0, 32'h40, 32'h0, 4'hF, 8'd2));
    resp_q.push_back(mk_resp(1, 32'h12345678));
    serve(2, 32'h12345678);
    bus.d_read = 0;
    tick();

    // requester address changes mid-transaction
    bus.d_read = 1; bus.d_address = 32'h10; bus.d_byte_enable = 4'h0;
    cmd_q.push_back(mk_cmd(1, 0, 32'h10, 32'h0, 4'hF, 8'd3));
    resp_q.push_back(mk_resp(1, 32'hA5A5));
    tick();
    bus.d_address = 32'h20;
    tick();
    tick();
    bus.mem_resp = 1; bus.mem_rdata = 32'hA5A5;
    @(negedge clk);
    chk("stable_addr_at_resp", bus.mem_address, 32'h10);
    tick();
    bus.mem_resp = 0; bus.mem_rdata = '0; bus.d_read = 0;
    tick();

    // spurious response in IDLE
    bus.mem_resp = 1; bus.mem_rdata = 32'hFFFF;
    @(negedge clk);
    chk("spurious_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("spurious_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
    tick();
    bus.mem_resp = 0; bus.mem_rdata = '0;
    @(negedge clk);
    chk("spurious_no_cmd", {bus.mem_read, bus.mem_write}, 2'b00);
    tick();

    // reset together with mem_resp in SERVE_I
    bus.i_read = 1; bus.i_address = 32'h700;
    cmd_q.push_back(mk_cmd(1, 0, 32'h700, 32'h0, 4'hF, 8'd2));
    tick();
    tick();
    rst = 1; bus.mem_resp = 1; bus.mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("rst_resp_i", bus.i_resp, 1'b0);
    chk("rst_resp_rdata", bus.i_rdata, 32'h0);
    tick();
    rst = 0; bus.mem_resp = 0; bus.mem_rdata = '0; bus.i_read = 0;
    @(negedge clk);
    chk("rst_drop_read", bus.mem_read, 1'b0);
    chk("rst_drop_addr", bus.mem_address, 32'h0);
    tick();

    // back in IDLE: a new fetch starts one cycle after request
    bus.i_read = 1; bus.i_address = 32'h104;
    cmd_q.push_back(mk_cmd(1, 0, 32'h104, 32'h0, 4'hF, 8'd1));
    resp_q.push_back(mk_resp(0, 32'h1111));
    serve(1, 32'h1111);
    bus.i_read = 0;
    tick();

    // contention after reset
    rst = 1;
    tick();
    rst = 0;
    bus.i_read = 1; bus.i_address = 32'h500;
    bus.d_read = 1; bus.d_address = 32'h600; bus.d_wdata = '0; bus.d_byte_enable = '0;
    for (int k = 0; k < 4; k++) begin
      logic sd;
`ifdef ARB_ROUND_ROBIN_EN
      sd = (k % 2 == 0);
`else
      sd = 1'b1;
`endif
      cmd_q.push_back(mk_cmd(1, 0, sd ? 32'h600 : 32'h500, 32'h0, 4'hF, 8'd1));
      resp_q.push_back(mk_resp(sd, 32'h1000 + k));
      serve(1, 32'h1000 + k);
    end
    bus.i_read = 0; bus.d_read = 0;
    repeat (3) tick();

    chk("resp_q_drained", resp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
